// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic-operations library.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_state_t;

  // Carry seed that turns a + ~b into a - b.
  localparam logic CARRY_SEED_SUB = 1'b1;

endpackage

// File: rtl/one_bit_adder.sv
// One-bit full-adder cell shared by the ripple and serial arithmetic blocks.
module one_bit_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  assign sum_c  = a ^ b ^ cin;
  assign cout_c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, diff = a - b, one bit per clock LSB first.
// Optional signed-overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  , output logic           overflow
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_state_t    state, state_nxt;
  logic             accept_c;
  logic             last_c;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             sum_c;
  logic             cout_c;

  one_bit_adder u_cell (
    .a      (a_q[0]),
    .b      (nb_q[0]),
    .cin    (carry_q),
    .sum_c  (sum_c),
    .cout_c (cout_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start is honoured only in IDLE or DONE
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry, counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      nb_q       <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow   <= 1'b0;
`endif
    end else if (accept_c) begin
      a_q     <= a;
      nb_q    <= ~b;
      carry_q <= CARRY_SEED_SUB;
      cnt_q   <= '0;
    end else if (state == SHIFT) begin
      a_q     <= a_q >> 1;
      nb_q    <= nb_q >> 1;
      res_q   <= {sum_c, res_q[WIDTH-1:1]};
      carry_q <= cout_c;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_c) begin
        diff       <= {sum_c, res_q[WIDTH-1:1]};
        borrow_out <= ~cout_c;
`ifdef SERIAL_SUB_OVERFLOW_EN
        // MSB step: carry-in differs from carry-out on signed overflow
        overflow   <= carry_q ^ cout_c;
`endif
      end
    end
  end

  // Handshake flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): vector table plus handshake/reset sequences.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; returns edges from E0 to done
  task automatic launch_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_, output int n);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    launch_and_wait(v.a, v.b, n);
    check("latency", 32'(n), 32'(W));
    check("diff", 32'(diff), 32'(v.d));
    check("borrow", 32'(borrow_out), 32'(v.bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("overflow", 32'(overflow), 32'(v.ov));
`endif
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("diff_hold", 32'(diff), 32'(v.d));
  endtask

  initial begin
    vec_t vecs[8];
    int   n, dones;
    logic [W-1:0] seen;

    vecs[0] = '{8'd10,  8'd3,   8'h07, 1'b0, 1'b0};
    vecs[1] = '{8'd3,   8'd10,  8'hF9, 1'b1, 1'b0};
    vecs[2] = '{8'h00,  8'h00,  8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF,  8'hFF,  8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80,  8'h01,  8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F,  8'hFF,  8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h01,  8'h02,  8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hC8,  8'h64,  8'h64, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Start pulsed mid-SHIFT with new operands must be ignored
    @(negedge clk);
    a = 8'd20; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; seen = '0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) begin
        @(negedge clk);
        a = 8'd100; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        e++;
      end else begin
        @(posedge clk); #1;
      end
      if (done) begin
        dones++;
        seen = diff;
        check("ign_done_edge", 32'(e), 32'(W));
      end
    end
    check("ign_done_count", 32'(dones), 32'd1);
    check("ign_diff", 32'(seen), 32'h0F);

    // Start held high through DONE: second op starts with no IDLE gap
    @(negedge clk);
    a = 8'd9; b = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_lat1", 32'(n), 32'(W));
    check("b2b_diff1", 32'(diff), 32'h05);
    a = 8'd50; b = 8'd8;
    @(posedge clk); #1;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_drop", 32'(done), 32'd0);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_lat2", 32'(n), 32'(W));
    check("b2b_diff2", 32'(diff), 32'h2A);
    check("b2b_borrow2", 32'(borrow_out), 32'd0);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    a = 8'd200; b = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("mid_rst_ovf", 32'(overflow), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    run_vec('{8'd5, 8'd2, 8'h03, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
